regfile_write_arbiter: RTL and testbench

Shares the single write port of the 16 x 18-bit register file among NUM_REQ writeback sources (ALU, load unit, multi-cycle unit), using a valid/ready handshake.
Registers the granted write and drives the register file write port with 1-cycle latency.
Keeps a 16-entry busy scoreboard of registers with reserved, still-pending writes, and reports read-operand hazards to the decode stage.

---
 rtl/regfile_pkg.sv | 24 ++
 rtl/rr_arbiter.sv | 81 ++++++++
 rtl/regfile_write_arbiter.sv | 121 ++++++++++++
 tb/tb_regfile_write_arbiter.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// ---------------------------------------------------------------------------
// regfile_pkg
// Shared constants, types and helpers for the register-file write path.
//   DATA_W     register data width (18)
//   ADDR_W     register address width (4)
//   NUM_REGS   number of registers (16 = 2**ADDR_W)
//   reg_addr_t register address type
//   reg_data_t register data type
//   wrap_inc   modulo-n increment of a requester index
// ---------------------------------------------------------------------------
package regfile_pkg;

    localparam int DATA_W   = 18;
    localparam int ADDR_W   = 4;
    localparam int NUM_REGS = 16;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] reg_data_t;

    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// One-hot request arbiter for the register-file write port.
// Build option: RR_ARB_EN defined   -> round-robin, search starts at an
//                                      internal pointer and wraps modulo N;
//                                      pointer moves past the winner when
//                                      advance is high.
//               RR_ARB_EN undefined -> fixed priority, lowest index wins,
//                                      no pointer state.
// Ports:
//   clk      system clock, rising edge
//   rst_n    synchronous active-low reset (pointer -> 0)
//   req      per-requester request
//   advance  a grant was taken this cycle; update the pointer
//   grant    one-hot grant (all zero when no request)
// ---------------------------------------------------------------------------
module rr_arbiter
    import regfile_pkg::*;
#(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] grant
);

    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

`ifdef RR_ARB_EN
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] ptr_next;

    // Walk the requesters starting at ptr; the first hit wins and the
    // candidate next pointer is the slot just after it.
    always_comb begin
        int unsigned idx;
        logic        found;
        grant    = '0;
        ptr_next = ptr;
        found    = 1'b0;
        idx      = 0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = 32'(ptr) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!found && req[idx[IDX_W-1:0]]) begin
                found                  = 1'b1;
                grant[idx[IDX_W-1:0]]  = 1'b1;
                ptr_next               = IDX_W'(wrap_inc(idx, N));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= ptr_next;
        end
    end
`else
    logic unused_inputs;
    assign unused_inputs = ^{clk, rst_n, advance};

    always_comb begin
        logic found;
        grant = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            if (!found && req[k[IDX_W-1:0]]) begin
                found                = 1'b1;
                grant[k[IDX_W-1:0]]  = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/regfile_write_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_write_arbiter
// Shares the single register-file write port among NUM_REQ writeback
// sources (valid/ready), registers the granted write (1-cycle latency) and
// keeps a busy scoreboard of registers with pending writes for decode.
// Build option: RR_ARB_EN selects round-robin arbitration; when undefined
// the lowest-index requester always wins.
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   req_valid/addr/data        per-requester write request (slot-packed)
//   req_ready                  one-hot accept, combinational
//   rsv_valid, rsv_addr        decode reserves a destination register
//   read_register_1/2          decode operand addresses
//   rd_busy_1/2                operand has a pending write
//   write_register/data        register-file write port
//   reg_write                  register-file write enable
//   busy_vec                   scoreboard, bit n = register n pending
// ---------------------------------------------------------------------------
module regfile_write_arbiter #(
    parameter int NUM_REQ  = 3,
    parameter int DATA_W   = regfile_pkg::DATA_W,
    parameter int ADDR_W   = regfile_pkg::ADDR_W,
    parameter int NUM_REGS = regfile_pkg::NUM_REGS
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      rsv_valid,
    input  logic [ADDR_W-1:0]         rsv_addr,
    input  logic [ADDR_W-1:0]         read_register_1,
    input  logic [ADDR_W-1:0]         read_register_2,
    output logic                      rd_busy_1,
    output logic                      rd_busy_2,
    output logic [ADDR_W-1:0]         write_register,
    output logic [DATA_W-1:0]         write_data,
    output logic                      reg_write,
    output logic [NUM_REGS-1:0]       busy_vec
);

    import regfile_pkg::*;

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]  gated_req;
    logic [NUM_REQ-1:0]  grant;
    logic                grant_any;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_data;
    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_next;

    // Masking requests during reset keeps req_ready low and stops the
    // arbiter pointer from advancing on a write that will be dropped.
    assign gated_req = rst_n ? req_valid : '0;
    assign grant_any = |grant;
    assign req_ready = grant;

    rr_arbiter #(
        .N (NUM_REQ)
    ) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (gated_req),
        .advance (grant_any),
        .grant   (grant)
    );

    // Grant is one-hot, so a plain select loop is sufficient.
    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant[i[IDX_W-1:0]]) begin
                sel_addr = req_addr[i*ADDR_W +: ADDR_W];
                sel_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            reg_write      <= 1'b0;
            write_register <= '0;
            write_data     <= '0;
        end else begin
            reg_write <= grant_any;
            if (grant_any) begin
                write_register <= sel_addr;
                write_data     <= sel_data;
            end
        end
    end

    // Clear before set: a same-edge reservation of the register being
    // written is a new reservation and must survive.
    always_comb begin
        busy_next = busy;
        if (grant_any) begin
            busy_next[sel_addr] = 1'b0;
        end
        if (rsv_valid) begin
            busy_next[rsv_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    assign busy_vec  = busy;
    assign rd_busy_1 = busy[read_register_1];
    assign rd_busy_2 = busy[read_register_2];

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_regfile_write_arbiter
// Directed and randomized stimulus against a behavioural model of the
// write arbiter. Writes expected on the register-file port are queued when
// the model predicts a grant and popped by an independent port monitor.
// ---------------------------------------------------------------------------
module tb_regfile_write_arbiter;
    import regfile_pkg::*;

    localparam int NUM_REQ = 3;

    logic                      clk;
    logic                      rst_n;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      rsv_valid;
    logic [ADDR_W-1:0]         rsv_addr;
    logic [ADDR_W-1:0]         read_register_1;
    logic [ADDR_W-1:0]         read_register_2;
    logic                      rd_busy_1;
    logic                      rd_busy_2;
    logic [ADDR_W-1:0]         write_register;
    logic [DATA_W-1:0]         write_data;
    logic                      reg_write;
    logic [NUM_REGS-1:0]       busy_vec;

    regfile_write_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .NUM_REGS (NUM_REGS)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_valid       (req_valid),
        .req_addr        (req_addr),
        .req_data        (req_data),
        .req_ready       (req_ready),
        .rsv_valid       (rsv_valid),
        .rsv_addr        (rsv_addr),
        .read_register_1 (read_register_1),
        .read_register_2 (read_register_2),
        .rd_busy_1       (rd_busy_1),
        .rd_busy_2       (rd_busy_2),
        .write_register  (write_register),
        .write_data      (write_data),
        .reg_write       (reg_write),
        .busy_vec        (busy_vec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        reg_addr_t a;
        reg_data_t d;
    } wr_t;

    wr_t                 wq[$];
    int                  total_checks = 0;
    int                  fail_checks  = 0;
    int                  model_grant  = -1;
    int                  m_ptr        = 0;
    logic [NUM_REGS-1:0] m_busy       = '0;
    reg_addr_t           held_a       = '0;
    reg_data_t           held_d       = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_checks++;
        if (act !== exp) begin
            fail_checks++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // First requesting index found scanning upward from p, wrapping.
    function automatic int pick(input logic [NUM_REQ-1:0] v, input int p);
        for (int k = 0; k < NUM_REQ; k++) begin
            int i;
            i = (p + k) % NUM_REQ;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    // Reference model: checks combinational outputs mid-cycle, then
    // advances its own state for the coming edge.
    initial begin
        forever begin
            int                  g;
            logic [NUM_REQ-1:0]  exp_ready;
            wr_t                 w;
            @(negedge clk);
            if (!rst_n) begin
                g = -1;
            end else begin
`ifdef RR_ARB_EN
                g = pick(req_valid, m_ptr);
`else
                g = pick(req_valid, 0);
`endif
            end
            exp_ready = (g >= 0) ? NUM_REQ'(1 << g) : '0;
            check("req_ready", 32'(req_ready), 32'(exp_ready));
            check("busy_vec", 32'(busy_vec), 32'(m_busy));
            check("rd_busy_1", 32'(rd_busy_1), 32'(m_busy[read_register_1]));
            check("rd_busy_2", 32'(rd_busy_2), 32'(m_busy[read_register_2]));
            model_grant = g;
            if (!rst_n) begin
                m_busy = '0;
                m_ptr  = 0;
                held_a = '0;
                held_d = '0;
            end else begin
                if (g >= 0) begin
                    w.a = req_addr[g*ADDR_W +: ADDR_W];
                    w.d = req_data[g*DATA_W +: DATA_W];
                    wq.push_back(w);
                    m_busy[w.a] = 1'b0;
                    m_ptr = (g + 1) % NUM_REQ;
                end
                if (rsv_valid) m_busy[rsv_addr] = 1'b1;
            end
        end
    end

    // Write-port monitor.
    initial begin
        forever begin
            wr_t w;
            @(posedge clk);
            #2;
            check("reg_write", 32'(reg_write), 32'(wq.size() > 0));
            if (wq.size() > 0) begin
                w = wq.pop_front();
                held_a = w.a;
                held_d = w.d;
            end
            check("write_register", 32'(write_register), 32'(held_a));
            check("write_data", 32'(write_data), 32'(held_d));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input reg_addr_t a, input reg_data_t d);
        req_valid[i] = v;
        req_addr[i*ADDR_W +: ADDR_W] = a;
        req_data[i*DATA_W +: DATA_W] = d;
    endtask

    task automatic random_cycle();
        step();
        for (int i = 0; i < NUM_REQ; i++) begin
            if (model_grant == i || !req_valid[i]) begin
                if ($urandom_range(0, 3) != 0)
                    set_req(i, 1'b1, ADDR_W'($urandom), DATA_W'($urandom));
                else
                    req_valid[i] = 1'b0;
            end
        end
        rsv_valid       = 1'($urandom_range(0, 1));
        rsv_addr        = ADDR_W'($urandom);
        read_register_1 = ADDR_W'($urandom);
        read_register_2 = ADDR_W'($urandom);
    endtask

    initial begin
        rst_n = 1'b0;
        rsv_valid = 1'b0;
        rsv_addr = '0;
        read_register_1 = '0;
        read_register_2 = '0;
        for (int i = 0; i < NUM_REQ; i++)
            set_req(i, 1'b1, ADDR_W'(i + 1), DATA_W'(18'h100 + i));

        // Reset held for two edges with every requester valid.
        step();
        step();
        rst_n = 1'b1;

        // All valid for six edges: rotation (or requester 0 every time).
        repeat (6) step();
        req_valid = '0;
        step();

        // Single write from requester 0.
        set_req(0, 1'b1, 4'd5, 18'h2A5A5);
        step();
        req_valid = '0;
        step();
        step();

        // Reserve r7, observe hazard, then requester 1 retires it.
        rsv_valid = 1'b1;
        rsv_addr  = 4'd7;
        step();
        rsv_valid = 1'b0;
        read_register_1 = 4'd7;
        step();
        set_req(1, 1'b1, 4'd7, 18'h3FFFF);
        step();
        req_valid = '0;
        step();

        // Reservation and write of r3 on the same edge: stays busy.
        rsv_valid = 1'b1;
        rsv_addr  = 4'd3;
        set_req(0, 1'b1, 4'd3, 18'h00001);
        read_register_2 = 4'd3;
        step();
        rsv_valid = 1'b0;
        req_valid = '0;
        step();

        // Randomized traffic with a reset dropped in mid-stream.
        repeat (200) random_cycle();
        step();
        rst_n = 1'b0;
        req_valid = '1;
        step();
        rst_n = 1'b1;
        repeat (200) random_cycle();

        step();
        req_valid = '0;
        rsv_valid = 1'b0;
        repeat (3) step();
        check("drain", 32'(wq.size()), 32'd0);

        $display("%0d/%0d checks passed", total_checks - fail_checks, total_checks);
        $finish;
    end

endmodule
